// File: rtl/rom_load_sequencer_if.sv
// rtl/rom_load_sequencer_if.sv - SDRAM word-write request/acknowledge bus
interface rom_load_sequencer_if #(
    parameter int AW = 24
);
    logic          wr_req;
    logic [AW-2:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - ROM download header latch, byte-to-word packer, SDRAM write queue
module rom_load_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ext_reset,
    input  logic                 ioctl_downl,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [3:0]           pcb,
    output logic                 tate,
    output logic [7:0]           brd,
    rom_load_sequencer_if.master sdram,
    output logic                 rom_loaded,
    output logic                 core_reset,
    output logic                 overflow
);
    localparam int WAW = AW - 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic downl_q;
    logic rise;
    logic fall;

    logic           pend_valid;
    logic [WAW-1:0] pend_addr;
    logic [7:0]     pend_data;
    logic           def_valid;
    logic [WAW-1:0] def_addr;
    logic [15:0]    def_data;

    logic [24:0]    p;
    logic           strobe;
    logic           is_pay;
    logic [WAW-1:0] p_word;
    logic           match;

    logic           push_valid;
    logic [WAW-1:0] push_addr;
    logic [15:0]    push_data;
    logic           def_load;
    logic           def_clr;
    logic           pend_load;
    logic           pend_clr;

    logic           enter_load;
    logic           set_loaded;
    logic           flush_ok;

    logic [WAW+15:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic            fifo_empty;
    logic            full;
    logic            pop;
    logic            push_ok;

    logic unused_bits;

    assign rise   = ioctl_downl & ~downl_q;
    assign fall   = ~ioctl_downl & downl_q;
    assign p      = ioctl_addr - 25'd2;
    assign strobe = ioctl_wr & ioctl_downl;
    assign is_pay = strobe & (ioctl_addr > 25'd1);
    assign p_word = p[AW-1:1];
    assign match  = pend_valid & (pend_addr == p_word);

    assign unused_bits = ^{ioctl_dout[6:4], p[24:AW]};

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a re-raised download in DRAIN waits for the queue to empty
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (rise) state_nx = LOAD;
            LOAD:  if (fall) state_nx = DRAIN;
            DRAIN: if (fifo_empty && !def_valid && !push_valid) begin
                       if (ioctl_downl)      state_nx = LOAD;
                       else if (!pend_valid) state_nx = DONE;
                   end
            DONE:  if (rise) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        enter_load = (state_nx == LOAD) && (state != LOAD);
        set_loaded = (state == DRAIN) && (state_nx == DONE);
        flush_ok   = (state == DRAIN) && !ioctl_downl;
    end

    // Word assembly; the stream gap keeps a deferred word from meeting a new strobe
    always_comb begin
        push_valid = 1'b0;
        push_addr  = def_addr;
        push_data  = def_data;
        def_load   = 1'b0;
        def_clr    = 1'b0;
        pend_load  = 1'b0;
        pend_clr   = 1'b0;
        if (def_valid) begin
            push_valid = 1'b1;
            def_clr    = 1'b1;
        end
        if (is_pay) begin
            if (!p[0]) begin
                if (pend_valid) begin
                    push_valid = 1'b1;
                    push_addr  = pend_addr;
                    push_data  = {pend_data, 8'hFF};
                end
                pend_load = 1'b1;
            end else if (match) begin
                push_valid = 1'b1;
                push_addr  = p_word;
                push_data  = {pend_data, ioctl_dout};
                pend_clr   = 1'b1;
            end else if (pend_valid) begin
                push_valid = 1'b1;
                push_addr  = pend_addr;
                push_data  = {pend_data, 8'hFF};
                pend_clr   = 1'b1;
                def_load   = 1'b1;
            end else begin
                push_valid = 1'b1;
                push_addr  = p_word;
                push_data  = {8'hFF, ioctl_dout};
            end
        end else if (flush_ok && pend_valid && !def_valid) begin
            push_valid = 1'b1;
            push_addr  = pend_addr;
            push_data  = {pend_data, 8'hFF};
            pend_clr   = 1'b1;
        end
    end

    assign fifo_empty = (count == '0);
    assign full       = (count == DEPTH_C);
    assign pop        = sdram.wr_ack & ~fifo_empty;
    assign push_ok    = push_valid & (~full | pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr] <= {push_addr, push_data};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign sdram.wr_req  = ~fifo_empty;
    assign sdram.wr_addr = fifo_empty ? '0 : mem[rd_ptr][WAW+15:16];
    assign sdram.wr_data = fifo_empty ? '0 : mem[rd_ptr][15:0];

    // Header, pending/deferred bytes, status flags and core reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            downl_q    <= 1'b0;
            pcb        <= '0;
            tate       <= 1'b0;
            brd        <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            def_valid  <= 1'b0;
            def_addr   <= '0;
            def_data   <= '0;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            downl_q <= ioctl_downl;
            if (strobe && ioctl_addr == 25'd0) begin
                tate <= ioctl_dout[7];
                pcb  <= ioctl_dout[3:0];
            end
            if (strobe && ioctl_addr == 25'd1) brd <= ioctl_dout;
            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_addr  <= p_word;
                pend_data  <= ioctl_dout;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
            if (def_load) begin
                def_valid <= 1'b1;
                def_addr  <= p_word;
                def_data  <= {8'hFF, ioctl_dout};
            end else if (def_clr) begin
                def_valid <= 1'b0;
            end
            if (enter_load)      rom_loaded <= 1'b0;
            else if (set_loaded) rom_loaded <= 1'b1;
            if (enter_load)                       overflow <= 1'b0;
            else if (push_valid && full && !pop) overflow <= 1'b1;
            core_reset <= ext_reset | ioctl_downl | ~rom_loaded;
        end
    end
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - directed table-driven bench for rom_load_sequencer
module tb_rom_load_sequencer;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ext_reset = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [3:0]  pcb;
    logic        tate;
    logic [7:0]  brd;
    logic        rom_loaded;
    logic        core_reset;
    logic        overflow;

    logic ack_en = 1'b0;
    logic man_ack = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [38:0] got_q[$];
    logic [38:0] exp_q[$];

    rom_load_sequencer_if #(.AW(24)) bus ();

    rom_load_sequencer #(.FIFO_DEPTH(4), .AW(24)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ext_reset   (ext_reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .pcb         (pcb),
        .tate        (tate),
        .brd         (brd),
        .sdram       (bus),
        .rom_loaded  (rom_loaded),
        .core_reset  (core_reset),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: acks every other cycle when enabled, or on demand
    initial bus.wr_ack = 1'b0;
    always @(posedge clk_sys) begin
        #2;
        bus.wr_ack = man_ack | (ack_en & bus.wr_req & ~bus.wr_ack);
    end

    always @(negedge clk_sys) begin
        if (bus.wr_req && bus.wr_ack) got_q.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  dout;
        logic [3:0]  pcb;
        logic        tate;
        logic [7:0]  brd;
        int          nwr;
        logic [38:0] last_wr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] w(input int a, input logic [15:0] d);
        logic [22:0] aa;
        aa = 23'(a);
        return {aa, d};
    endfunction

    task automatic send_byte(input int a, input logic [7:0] d);
        @(posedge clk_sys) #1;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        @(posedge clk_sys) #1;
        ioctl_wr = 1'b0;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic start_dl();
        @(posedge clk_sys) #1;
        ioctl_downl = 1'b1;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rom_loaded cleared on load", rom_loaded, 1'b0);
        check("core_reset during load", core_reset, 1'b1);
    endtask

    task automatic end_dl_wait(input string name);
        bit seen;
        seen = 1'b0;
        @(posedge clk_sys) #1;
        ioctl_downl = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk_sys);
            if (rom_loaded) seen = 1'b1;
        end
        check({name, " rom_loaded"}, seen, 1'b1);
        if (seen) begin
            check({name, " core_reset still high"}, core_reset, 1'b1);
            @(negedge clk_sys);
            check({name, " core_reset released"}, core_reset, 1'b0);
        end
    endtask

    task automatic check_writes(input string name);
        check({name, " write count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s write %0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        tbl[0] = '{addr: 25'd0, dout: 8'h83, pcb: 4'h3, tate: 1'b1, brd: 8'h00, nwr: 0, last_wr: '0};
        tbl[1] = '{addr: 25'd1, dout: 8'h15, pcb: 4'h3, tate: 1'b1, brd: 8'h15, nwr: 0, last_wr: '0};
        tbl[2] = '{addr: 25'd2, dout: 8'hAA, pcb: 4'h3, tate: 1'b1, brd: 8'h15, nwr: 0, last_wr: '0};
        tbl[3] = '{addr: 25'd3, dout: 8'hBB, pcb: 4'h3, tate: 1'b1, brd: 8'h15, nwr: 1, last_wr: w(0, 16'hAABB)};
        tbl[4] = '{addr: 25'd4, dout: 8'hCC, pcb: 4'h3, tate: 1'b1, brd: 8'h15, nwr: 1, last_wr: w(0, 16'hAABB)};
        tbl[5] = '{addr: 25'd5, dout: 8'hDD, pcb: 4'h3, tate: 1'b1, brd: 8'h15, nwr: 2, last_wr: w(1, 16'hCCDD)};

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset pcb", pcb, 4'h0);
        check("reset tate", tate, 1'b0);
        check("reset brd", brd, 8'h00);
        check("reset wr_req", bus.wr_req, 1'b0);
        check("reset wr_addr", bus.wr_addr, 23'h0);
        check("reset wr_data", bus.wr_data, 16'h0);
        check("reset rom_loaded", rom_loaded, 1'b0);
        check("reset overflow", overflow, 1'b0);
        check("reset core_reset", core_reset, 1'b1);
        @(posedge clk_sys) #1;
        reset = 1'b0;

        // Stray ack with an empty queue must not disturb anything
        @(posedge clk_sys) #1;
        man_ack = 1'b1;
        @(posedge clk_sys) #1;
        man_ack = 1'b0;
        @(negedge clk_sys);
        check("stray ack wr_req", bus.wr_req, 1'b0);

        // Basic download, table driven
        ack_en = 1'b1;
        start_dl();
        for (int i = 0; i < 6; i++) begin
            send_byte(int'(tbl[i].addr), tbl[i].dout);
            @(negedge clk_sys);
            check($sformatf("vec%0d pcb", i), pcb, tbl[i].pcb);
            check($sformatf("vec%0d tate", i), tate, tbl[i].tate);
            check($sformatf("vec%0d brd", i), brd, tbl[i].brd);
            check($sformatf("vec%0d nwr", i), got_q.size(), tbl[i].nwr);
            check($sformatf("vec%0d wr_req idle", i), bus.wr_req, 1'b0);
            if (tbl[i].nwr > 0 && got_q.size() >= tbl[i].nwr)
                check($sformatf("vec%0d last write", i), got_q[tbl[i].nwr-1], tbl[i].last_wr);
        end
        end_dl_wait("basic");

        // ext_reset pulses core_reset
        @(posedge clk_sys) #1;
        ext_reset = 1'b1;
        @(posedge clk_sys) #1;
        ext_reset = 1'b0;
        @(negedge clk_sys);
        check("ext_reset core_reset", core_reset, 1'b1);
        @(negedge clk_sys);
        check("ext_reset release", core_reset, 1'b0);

        // Odd payload length: last byte padded with FF
        got_q.delete();
        start_dl();
        send_byte(2, 8'h11);
        send_byte(3, 8'h22);
        send_byte(4, 8'hEE);
        end_dl_wait("odd");
        exp_q.delete();
        exp_q.push_back(w(0, 16'h1122));
        exp_q.push_back(w(1, 16'hEEFF));
        check_writes("odd");

        // Overflow: no acks, six words pushed into a four-deep queue
        got_q.delete();
        ack_en = 1'b0;
        start_dl();
        send_byte(0, 8'h02);
        send_byte(1, 8'h07);
        for (int i = 0; i < 12; i++) begin
            send_byte(2 + i, 8'(8'h10 + i));
            if (i == 3) begin
                @(negedge clk_sys);
                check("ovf head early", {bus.wr_req, bus.wr_addr, bus.wr_data}, {1'b1, w(0, 16'h1011)});
                check("ovf not yet", overflow, 1'b0);
            end
        end
        @(negedge clk_sys);
        check("ovf header pcb/tate/brd", {pcb, tate, brd}, {4'h2, 1'b0, 8'h07});
        check("ovf head stable", {bus.wr_req, bus.wr_addr, bus.wr_data}, {1'b1, w(0, 16'h1011)});
        check("ovf flag", overflow, 1'b1);
        ack_en = 1'b1;
        repeat (20) @(posedge clk_sys);
        end_dl_wait("ovf");
        check("ovf sticky", overflow, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(w(i, {8'(8'h10 + 2*i), 8'(8'h11 + 2*i)}));
        check_writes("ovf");

        // Push and pop together while full
        got_q.delete();
        ack_en = 1'b0;
        start_dl();
        check("full test overflow cleared", overflow, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(2 + i, 8'(8'h20 + i));
        @(posedge clk_sys) #1;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd11;
        ioctl_dout = 8'h29;
        man_ack = 1'b1;
        @(posedge clk_sys) #1;
        ioctl_wr = 1'b0;
        man_ack = 1'b0;
        @(negedge clk_sys);
        check("full push+pop overflow", overflow, 1'b0);
        check("full push+pop head", {bus.wr_req, bus.wr_addr, bus.wr_data}, {1'b1, w(1, 16'h2223)});
        ack_en = 1'b1;
        repeat (20) @(posedge clk_sys);
        end_dl_wait("full");
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(w(i, {8'(8'h20 + 2*i), 8'(8'h21 + 2*i)}));
        check_writes("full");
        check("full overflow final", overflow, 1'b0);

        // Reset mid-load abandons the request
        got_q.delete();
        ack_en = 1'b0;
        start_dl();
        send_byte(0, 8'h05);
        send_byte(1, 8'h09);
        send_byte(2, 8'h31);
        send_byte(3, 8'h32);
        @(negedge clk_sys);
        check("mid reset req before", bus.wr_req, 1'b1);
        @(posedge clk_sys) #1;
        reset = 1'b1;
        ioctl_downl = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("mid reset wr_req", bus.wr_req, 1'b0);
        check("mid reset rom_loaded", rom_loaded, 1'b0);
        check("mid reset core_reset", core_reset, 1'b1);
        check("mid reset pcb", pcb, 4'h0);
        @(posedge clk_sys) #1;
        reset = 1'b0;
        ack_en = 1'b1;
        start_dl();
        send_byte(0, 8'h81);
        send_byte(1, 8'h44);
        send_byte(2, 8'h01);
        send_byte(3, 8'h02);
        send_byte(4, 8'h03);
        send_byte(5, 8'h04);
        end_dl_wait("after reset");
        check("after reset header", {pcb, tate, brd}, {4'h1, 1'b1, 8'h44});
        exp_q.delete();
        exp_q.push_back(w(0, 16'h0102));
        exp_q.push_back(w(1, 16'h0304));
        check_writes("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
